// File: rtl/bus_conn_pkg.sv
// Shared types and helpers for the bus-range to per-bit connection sequencer.
// Holds the controller state enum, the per-bit command bundle and range math.
package bus_conn_pkg;

  localparam int TERM_ID_W_D = 8;
  localparam int NET_ID_W_D  = 8;
  localparam int IDX_W_D     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [TERM_ID_W_D-1:0] term;
    logic [IDX_W_D-1:0]     term_bit;
    logic [NET_ID_W_D-1:0]  net;
    logic [IDX_W_D-1:0]     net_bit;
    logic                   connect;
    logic                   last;
  } cmd_t;

  localparam logic [IDX_W_D:0] W_ONE = 1;

  // Number of bits in [msb:lsb], either direction (1..2^IDX_W).
  function automatic logic [IDX_W_D:0] range_width(
    input logic [IDX_W_D-1:0] msb,
    input logic [IDX_W_D-1:0] lsb
  );
    logic [IDX_W_D-1:0] span;
    span = (msb >= lsb) ? (msb - lsb) : (lsb - msb);
    return {1'b0, span} + W_ONE;
  endfunction

  // Highest net bit touched lands past the top index.
  function automatic logic range_ovf(
    input logic [IDX_W_D-1:0] base,
    input logic [IDX_W_D:0]   width
  );
    logic [IDX_W_D:0] top;
    top = {1'b0, base} + width - W_ONE;
    return top[IDX_W_D];
  endfunction

endpackage

// File: rtl/bus_bit_walker.sv
// Bit-position walker: steps k from 0 to span, producing term/net bit indices.
// Ports: load/advance controls, range bounds in, term_bit/net_bit/last out.
module bus_bit_walker #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [IDX_W-1:0] ld_msb,
  input  logic [IDX_W-1:0] ld_lsb,
  input  logic [IDX_W-1:0] ld_base,
  output logic [IDX_W-1:0] term_bit,
  output logic [IDX_W-1:0] net_bit,
  output logic             last
);

  localparam logic [IDX_W-1:0] K_ONE = 1;

  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] span_q, span_d;
  logic [IDX_W-1:0] msb_q, msb_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic             desc_q, desc_d;

  always_comb begin
    k_d    = k_q;
    span_d = span_q;
    msb_d  = msb_q;
    base_d = base_q;
    desc_d = desc_q;
    if (load) begin
      desc_d = (ld_msb >= ld_lsb);
      msb_d  = ld_msb;
      base_d = ld_base;
      span_d = desc_d ? (ld_msb - ld_lsb)
                      : (ld_lsb - ld_msb);
      k_d    = '0;
    end else if (advance && (k_q != span_q)) begin
      k_d = k_q + K_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      span_q <= '0;
      msb_q  <= '0;
      base_q <= '0;
      desc_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      span_q <= span_d;
      msb_q  <= msb_d;
      base_q <= base_d;
      desc_q <= desc_d;
    end
  end

  // msb pairs with the highest net bit, so net walks down as k rises.
  assign term_bit = desc_q ? (msb_q - k_q) : (msb_q + k_q);
  assign net_bit  = base_q + (span_q - k_q);
  assign last     = (k_q == span_q);

endmodule

// File: rtl/bus_bit_connect_ctrl.sv
// Expands one term[msb:lsb] -> net[base..] request into per-bit commands.
// Ports: req_* handshake in, cmd_* handshake out, abort, done_* pulse out.
module bus_bit_connect_ctrl #(
  parameter int TERM_ID_W = 8,
  parameter int NET_ID_W  = 8,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TERM_ID_W-1:0] req_term,
  input  logic [IDX_W-1:0]     req_msb,
  input  logic [IDX_W-1:0]     req_lsb,
  input  logic [NET_ID_W-1:0]  req_net,
  input  logic [IDX_W-1:0]     req_net_base,
  input  logic                 req_connect,
  input  logic                 abort,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [TERM_ID_W-1:0] cmd_term,
  output logic [IDX_W-1:0]     cmd_term_bit,
  output logic [NET_ID_W-1:0]  cmd_net,
  output logic [IDX_W-1:0]     cmd_net_bit,
  output logic                 cmd_connect,
  output logic                 cmd_last,
  output logic                 done_valid,
  output logic                 done_err,
  output logic                 done_aborted,
  output logic [IDX_W:0]       done_count
);

  import bus_conn_pkg::*;

  localparam logic [IDX_W:0] C_ONE = 1;

  state_e               state_q, state_d;
  logic [TERM_ID_W-1:0] term_q, term_d;
  logic [NET_ID_W-1:0]  net_q, net_d;
  logic                 conn_q, conn_d;
  logic                 abort_q, abort_d;
  logic                 err_q, err_d;
  logic                 abrt_q, abrt_d;
  logic [IDX_W:0]       cnt_q, cnt_d;

  logic [IDX_W:0]   req_width;
  logic             req_ovf;
  logic             load;
  logic             advance;
  logic [IDX_W-1:0] w_term_bit;
  logic [IDX_W-1:0] w_net_bit;
  logic             w_last;
  logic             stop_req;
  cmd_t             cmd;

  assign req_width = range_width(req_msb, req_lsb);
  assign req_ovf   = range_ovf(req_net_base, req_width);

  bus_bit_walker #(
    .IDX_W (IDX_W)
  ) u_walker (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .advance  (advance),
    .ld_msb   (req_msb),
    .ld_lsb   (req_lsb),
    .ld_base  (req_net_base),
    .term_bit (w_term_bit),
    .net_bit  (w_net_bit),
    .last     (w_last)
  );

  // Abort raised in the same cycle as a handshake still counts.
  assign stop_req = abort_q | abort;

  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    net_d   = net_q;
    conn_d  = conn_q;
    abort_d = abort_q;
    err_d   = err_q;
    abrt_d  = abrt_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (req_valid) begin
          term_d = req_term;
          net_d  = req_net;
          conn_d = req_connect;
          cnt_d  = '0;
          abrt_d = 1'b0;
          err_d  = req_ovf;
          if (req_ovf) begin
            state_d = ST_DONE;
          end else begin
            load    = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        abort_d = stop_req;
        if (cmd_ready) begin
          advance = 1'b1;
          cnt_d   = cnt_q + C_ONE;
          if (w_last) begin
            state_d = ST_DONE;
          end else if (stop_req) begin
            abrt_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      term_q  <= '0;
      net_q   <= '0;
      conn_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      abrt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      net_q   <= net_d;
      conn_q  <= conn_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      abrt_q  <= abrt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command fields read as zero whenever no command is offered.
  always_comb begin
    cmd = '0;
    if (state_q == ST_RUN) begin
      cmd.term     = term_q;
      cmd.term_bit = w_term_bit;
      cmd.net      = net_q;
      cmd.net_bit  = w_net_bit;
      cmd.connect  = conn_q;
      cmd.last     = w_last;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign cmd_valid    = (state_q == ST_RUN);
  assign cmd_term     = cmd.term;
  assign cmd_term_bit = cmd.term_bit;
  assign cmd_net      = cmd.net;
  assign cmd_net_bit  = cmd.net_bit;
  assign cmd_connect  = cmd.connect;
  assign cmd_last     = cmd.last;

  assign done_valid   = (state_q == ST_DONE);
  assign done_err     = done_valid & err_q;
  assign done_aborted = done_valid & abrt_q;
  assign done_count   = done_valid ? cnt_q : '0;

endmodule

// File: tb/tb_bus_bit_connect_ctrl.sv
// Self-checking bench for bus_bit_connect_ctrl.
// Table vectors, hand sequences and random requests vs a range model.
module tb_bus_bit_connect_ctrl;

  localparam int TW = 8;
  localparam int NW = 8;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [TW-1:0] req_term;
  logic [IW-1:0] req_msb;
  logic [IW-1:0] req_lsb;
  logic [NW-1:0] req_net;
  logic [IW-1:0] req_net_base;
  logic          req_connect;
  logic          abort;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [TW-1:0] cmd_term;
  logic [IW-1:0] cmd_term_bit;
  logic [NW-1:0] cmd_net;
  logic [IW-1:0] cmd_net_bit;
  logic          cmd_connect;
  logic          cmd_last;
  logic          done_valid;
  logic          done_err;
  logic          done_aborted;
  logic [IW:0]   done_count;

  bus_bit_connect_ctrl #(
    .TERM_ID_W (TW),
    .NET_ID_W  (NW),
    .IDX_W     (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_term     (req_term),
    .req_msb      (req_msb),
    .req_lsb      (req_lsb),
    .req_net      (req_net),
    .req_net_base (req_net_base),
    .req_connect  (req_connect),
    .abort        (abort),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_term     (cmd_term),
    .cmd_term_bit (cmd_term_bit),
    .cmd_net      (cmd_net),
    .cmd_net_bit  (cmd_net_bit),
    .cmd_connect  (cmd_connect),
    .cmd_last     (cmd_last),
    .done_valid   (done_valid),
    .done_err     (done_err),
    .done_aborted (done_aborted),
    .done_count   (done_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int msb;
    int lsb;
    int base;
    int rnd;
    int ab_at;
    int stall;
    int e_err;
    int e_cnt;
    int e_ab;
  } vec_t;

  // Drive one request and check every command and the done pulse.
  // Expected bit pairs come from the range rule, not from the DUT.
  task automatic run_req(input vec_t v, input string tag);
    int  w, k, cyc, stalls, tbit, nbit;
    int  tid, nid, con;
    bit  ab, fin, exp_done, rdy;
    w   = (v.msb >= v.lsb) ? v.msb - v.lsb + 1 : v.lsb - v.msb + 1;
    tid = $urandom_range(0, 255);
    nid = $urandom_range(0, 255);
    con = $urandom_range(0, 1);
    @(negedge clk);
    chk({tag, " req_ready idle"}, req_ready, 1);
    req_valid    = 1'b1;
    req_term     = TW'(tid);
    req_net      = NW'(nid);
    req_msb      = IW'(v.msb);
    req_lsb      = IW'(v.lsb);
    req_net_base = IW'(v.base);
    req_connect  = con[0];
    @(negedge clk);
    req_valid    = 1'b0;
    req_term     = TW'($urandom);
    req_net      = NW'($urandom);
    req_msb      = IW'($urandom);
    req_lsb      = IW'($urandom);
    req_net_base = IW'($urandom);
    req_connect  = ~req_connect;
    k = 0; cyc = 0; stalls = 0;
    ab = 0; fin = 0;
    exp_done = (v.e_err != 0);
    while (!fin && cyc < 600) begin
      cyc++;
      if (exp_done) begin
        chk({tag, " done_valid"}, done_valid, 1);
        chk({tag, " cmd_valid@done"}, cmd_valid, 0);
        chk({tag, " done_err"}, done_err, v.e_err);
        chk({tag, " done_aborted"}, done_aborted, v.e_ab);
        chk({tag, " done_count"}, done_count, v.e_cnt);
        chk({tag, " done_cycle"}, cyc, k + stalls + 1);
        cmd_ready = 1'b0;
        abort     = 1'b0;
        fin       = 1;
      end else begin
        tbit = (v.msb >= v.lsb) ? v.msb - k : v.msb + k;
        nbit = v.base + w - 1 - k;
        chk({tag, " cmd_valid"}, cmd_valid, 1);
        chk({tag, " req_ready run"}, req_ready, 0);
        chk({tag, " term_bit"}, cmd_term_bit, tbit);
        chk({tag, " net_bit"}, cmd_net_bit, nbit);
        chk({tag, " cmd_last"}, cmd_last, (k == w - 1));
        chk({tag, " cmd_term"}, cmd_term, tid);
        chk({tag, " cmd_net"}, cmd_net, nid);
        chk({tag, " cmd_connect"}, cmd_connect, con);
        if (k == v.ab_at && !ab) begin
          abort = 1'b1;
          ab    = 1;
          rdy   = (v.stall == 0);
        end else begin
          abort = 1'b0;
          rdy   = (v.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        cmd_ready = rdy;
        if (rdy) begin
          if (k == w - 1 || ab) exp_done = 1;
          k++;
        end else begin
          stalls++;
        end
      end
      @(negedge clk);
    end
    chk({tag, " finished"}, fin, 1);
    chk({tag, " req_ready after"}, req_ready, 1);
    chk({tag, " done_valid after"}, done_valid, 0);
    chk({tag, " done_count after"}, done_count, 0);
  endtask

  vec_t tbl[12];

  initial begin
    vec_t rv;
    int   w;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_term     = '0;
    req_msb      = '0;
    req_lsb      = '0;
    req_net      = '0;
    req_net_base = '0;
    req_connect  = 1'b0;
    abort        = 1'b0;
    cmd_ready    = 1'b0;

    //          msb lsb base rnd ab stl err cnt ab
    tbl[0]  = '{31,  0,  0, 0, -1, 0, 0, 32, 0};
    tbl[1]  = '{ 1,  1,  0, 0, -1, 0, 0,  1, 0};
    tbl[2]  = '{ 0,  3,  4, 0, -1, 0, 0,  4, 0};
    tbl[3]  = '{ 7,  0, 60, 0, -1, 0, 1,  0, 0};
    tbl[4]  = '{ 7,  0,  0, 1,  2, 1, 0,  3, 1};
    tbl[5]  = '{63,  0,  0, 0, -1, 0, 0, 64, 0};
    tbl[6]  = '{ 0, 63,  0, 1, -1, 0, 0, 64, 0};
    tbl[7]  = '{ 5,  2, 59, 0, -1, 0, 0,  4, 0};
    tbl[8]  = '{ 5,  2, 61, 0, -1, 0, 1,  0, 0};
    tbl[9]  = '{ 3,  0, 60, 1, -1, 0, 0,  4, 0};
    tbl[10] = '{ 7,  0,  0, 0,  7, 0, 0,  8, 0};
    tbl[11] = '{ 7,  0,  0, 0,  3, 0, 0,  4, 1};

    #12;
    chk("rst req_ready", req_ready, 1);
    chk("rst cmd_valid", cmd_valid, 0);
    chk("rst done_valid", done_valid, 0);
    chk("rst done_count", done_count, 0);
    chk("rst cmd_term_bit", cmd_term_bit, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_req(tbl[i], $sformatf("vec%0d", i));

    // Abort while idle must not leak into the next request.
    @(negedge clk);
    abort = 1'b1;
    run_req('{9, 2, 10, 0, -1, 0, 0, 8, 0}, "idle_abort");

    // Reset in the middle of a 16-bit walk, at bit 5.
    @(negedge clk);
    req_valid    = 1'b1;
    req_msb      = 6'd15;
    req_lsb      = 6'd0;
    req_net_base = 6'd0;
    req_term     = 8'd5;
    req_net      = 8'd9;
    req_connect  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cmd_ready = 1'b1;
    for (int c = 0; c < 5; c++) @(negedge clk);
    chk("mid cmd_term_bit", cmd_term_bit, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst req_ready", req_ready, 1);
    chk("mrst cmd_valid", cmd_valid, 0);
    chk("mrst cmd_term_bit", cmd_term_bit, 0);
    chk("mrst cmd_net_bit", cmd_net_bit, 0);
    chk("mrst cmd_term", cmd_term, 0);
    chk("mrst cmd_last", cmd_last, 0);
    chk("mrst done_valid", done_valid, 0);
    chk("mrst done_count", done_count, 0);
    cmd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_req('{15, 0, 0, 0, -1, 0, 0, 16, 0}, "post_rst");

    for (int i = 0; i < 40; i++) begin
      rv.msb = $urandom_range(0, 63);
      rv.lsb = $urandom_range(0, 63);
      w = (rv.msb >= rv.lsb) ? rv.msb - rv.lsb + 1
                             : rv.lsb - rv.msb + 1;
      rv.base  = ($urandom_range(0, 1) != 0)
               ? $urandom_range(0, 64 - w) : $urandom_range(0, 63);
      rv.rnd   = 1;
      rv.ab_at = ($urandom_range(0, 9) < 3) ? $urandom_range(0, w - 1) : -1;
      rv.stall = $urandom_range(0, 1);
      rv.e_err = (rv.base + w - 1 > 63) ? 1 : 0;
      if (rv.e_err != 0) begin
        rv.e_cnt = 0;
        rv.e_ab  = 0;
      end else if (rv.ab_at < 0) begin
        rv.e_cnt = w;
        rv.e_ab  = 0;
      end else begin
        rv.e_cnt = rv.ab_at + 1;
        rv.e_ab  = (rv.ab_at < w - 1) ? 1 : 0;
      end
      run_req(rv, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/bus_bit_connect_ctrl.md
# bus_bit_connect_ctrl

Sequencer that expands one bus-range connection request (term bits [msb:lsb] to net bits starting at a base offset) into a stream of single-bit connect/disconnect commands, one per cycle. Feeds the netlist connection table that the Verilog backend later emits as per-bit assigns. Handles descending and ascending ranges, single-bit ranges with non-zero index (e.g. term [1:1] to net [0:0]), offset overflow and abort.

## Interface
- TERM_ID_W, 8, term identifier width
- NET_ID_W, 8, net identifier width
- IDX_W, 6, bit-index width (max index 2^IDX_W-1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_term  in  TERM_ID_W  term id
- req_msb  in  IDX_W  first term bit (left bound as declared)
- req_lsb  in  IDX_W  last term bit (right bound as declared)
- req_net  in  NET_ID_W  net id
- req_net_base  in  IDX_W  net bit mapped to req_lsb
- req_connect  in  1  1 = connect, 0 = disconnect
- abort  in  1  stop after the in-flight command
- cmd_valid  out  1  per-bit command valid
- cmd_ready  in  1  connection table accepts command
- cmd_term / cmd_term_bit / cmd_net / cmd_net_bit / cmd_connect  out  TERM_ID_W / IDX_W / NET_ID_W / IDX_W / 1  command fields
- cmd_last  out  1  final bit of the range
- done_valid  out  1  one-cycle completion pulse
- done_err  out  1  request rejected (overflow)
- done_aborted  out  1  request ended by abort
- done_count  out  IDX_W+1  bits handshaked for this request

## Operation
- width = |msb - lsb| + 1 (range 1..2^IDX_W).
- Walk order: k = 0..width-1, starting at msb. term_bit = msb - k if msb >= lsb, else msb + k. net_bit = net_base + (width-1-k). So msb maps to net_base+width-1, lsb maps to net_base.
- Overflow: net_base + width - 1 > 2^IDX_W - 1 (computed at IDX_W+1 bits) -> no commands, done_err=1, done_count=0.
- States: IDLE (req_ready=1) -> RUN on accept if no overflow, else DONE with err. RUN: cmd_valid=1, fields held stable until cmd_ready; on handshake advance k; handshake with cmd_last -> DONE. DONE: done_valid=1 one cycle -> IDLE.
- Abort: sampled in RUN every cycle, latched. Current cmd (valid already high) must still complete its handshake; at that handshake go to DONE with done_aborted=1 regardless of cmd_last. Abort in IDLE/DONE ignored. If abort coincides with the last handshake, done_aborted=0 (range completed).
- done_count = number of completed handshakes; width on normal completion.
- Request fields latched on accept; later changes on req_* ignored.
- Reset (any time, including mid-RUN): state IDLE, req_ready=1, cmd_valid=0, done_valid=0, done_err=0, done_aborted=0, done_count=0, all cmd_* fields 0, abort latch cleared. No partial command survives reset.

## Timing
- Accept at cycle T -> first cmd_valid at T+1.
- With cmd_ready held high: one command per cycle, last handshake at T+width, done_valid at T+width+1, req_ready at T+width+2.
- Overflow: accept T, done_valid with done_err at T+1, req_ready at T+2.
- cmd_ready low stalls the walk; no bit skipped or repeated.
- req_ready low in RUN and DONE; no request pipelining.
- done_* fields valid only with done_valid, zero otherwise.

## Structure
- Package bus_conn_pkg: state enum (IDLE, RUN, DONE), packed cmd struct (term, term_bit, net, net_bit, connect, last), width/overflow helper function.
- Sub-module bus_bit_walker: holds k, direction, msb, net_base; outputs term_bit, net_bit, last; advance input. Controller FSM, abort latch and done counters in top.

## Test plan
- msb=31, lsb=0, net_base=0, cmd_ready=1 -> 32 commands term_bit 31..0 with net_bit 31..0, cmd_last on bit 0, done_count=32 at T+33.
- msb=1, lsb=1, net_base=0 -> single command term_bit 1 / net_bit 0, cmd_last=1, done_count=1.
- Ascending msb=0, lsb=3, net_base=4 -> term_bit 0,1,2,3 map net_bit 7,6,5,4.
- msb=7, lsb=0, net_base=60 (IDX_W=6) -> no cmd_valid, done_err=1, done_count=0 at T+1.
- 8-bit range, cmd_ready toggled randomly, abort pulsed while third command stalled -> third command held until handshake, then done_aborted=1, done_count=3.
- rst_n low during RUN at bit 5 of 16 -> all outputs reset values immediately; after release, new request runs from its msb.
